// File: rtl/fpu_pkg.sv
// Shared types and helpers for the FPU execute-stage controller.
package fpu_pkg;

    // Opcodes presented to the combinational FPU; 9..15 are illegal.
    typedef enum logic [3:0] {
        FADD   = 4'd0,
        FSUB   = 4'd1,
        FMUL   = 4'd2,
        FDIV   = 4'd3,
        FSGNJ  = 4'd4,
        FSGNJN = 4'd5,
        FEQ    = 4'd6,
        FLT    = 4'd7,
        FLE    = 4'd8
    } fpu_op_t;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StExec = 2'd1,
        StDone = 2'd2
    } fsm_state_e;

    // Cycles from accept to result for a given opcode.
    function automatic logic [3:0] op_latency(
        input logic [3:0]  op,
        input int unsigned add_lat,
        input int unsigned mul_lat,
        input int unsigned div_lat
    );
        case (op)
            FADD, FSUB: return 4'(add_lat);
            FMUL:       return 4'(mul_lat);
            FDIV:       return 4'(div_lat);
            default:    return 4'd1;
        endcase
    endfunction

    function automatic logic op_is_legal(input logic [3:0] op);
        return op <= 4'(FLE);
    endfunction

    // Only the arithmetic ops can report overflow.
    function automatic logic op_is_arith(input logic [3:0] op);
        return op <= 4'(FDIV);
    endfunction

endpackage

// File: rtl/fpu_lat_counter.sv
// 4-bit latency down-counter: load, decrement to zero, zero flag.
module fpu_lat_counter (
    input  logic       clk,
    input  logic       rstn,
    input  logic       clr,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       dec,
    output logic       zero
);

    logic [3:0] cnt_q;

    // Clear beats load beats decrement; the count saturates at zero.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= 4'd0;
        end else if (clr) begin
            cnt_q <= 4'd0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (dec && (cnt_q != 4'd0)) begin
            cnt_q <= cnt_q - 4'd1;
        end
    end

    assign zero = (cnt_q == 4'd0);

endmodule

// File: rtl/fpu_exec_ctrl.sv
// FPU execute-stage controller: accepts one op, holds operands for the
// combinational FPU for a per-op latency, then presents the captured result.
// Optional feature: define FPU_STICKY_OVF_EN to build the sticky overflow flag.
module fpu_exec_ctrl
    import fpu_pkg::*;
#(
    parameter int unsigned ADD_LAT = 2,
    parameter int unsigned MUL_LAT = 2,
    parameter int unsigned DIV_LAT = 6
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_op,
    input  logic [4:0]  in_rd,
    input  logic [31:0] in_src1,
    input  logic [31:0] in_src2,
    output logic [31:0] fpu_src1,
    output logic [31:0] fpu_src2,
    output logic [3:0]  fpu_op,
    input  logic [31:0] fpu_result,
    input  logic        fpu_ovf,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [4:0]  out_rd,
    output logic [31:0] out_data,
    output logic        out_ovf,
    output logic        busy,
    output logic        ovf_sticky,
    input  logic        ovf_clr
);

    localparam logic [1:0] IDLE = StIdle;
    localparam logic [1:0] EXEC = StExec;
    localparam logic [1:0] DONE = StDone;

    logic [1:0]  state_q, state_d;
    logic [3:0]  op_q;
    logic [4:0]  rd_q;
    logic [31:0] src1_q, src2_q;
    logic [31:0] data_q;
    logic        ovf_q;

    logic        accept;
    logic        handshake;
    logic        capture;
    logic        cnt_zero;
    logic [3:0]  load_val;
    logic        cap_ovf;

    // Flush blocks both accept and the output handshake in the same cycle.
    assign in_ready  = !flush && ((state_q == IDLE) || ((state_q == DONE) && out_ready));
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == DONE) && !flush;
    assign handshake = out_valid && out_ready;
    assign capture   = (state_q == EXEC) && cnt_zero && !flush;
    assign load_val  = op_latency(in_op, ADD_LAT, MUL_LAT, DIV_LAT) - 4'd1;
    assign cap_ovf   = op_is_arith(op_q) && fpu_ovf;

    fpu_lat_counter u_lat_counter (
        .clk      (clk),
        .rstn     (rstn),
        .clr      (flush),
        .load     (accept),
        .load_val (load_val),
        .dec      (state_q == EXEC),
        .zero     (cnt_zero)
    );

    // Next-state: flush always returns to IDLE; DONE chains straight into
    // EXEC when a new op is taken on the handshake edge.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (accept) state_d = EXEC;
                EXEC: if (cnt_zero) state_d = DONE;
                DONE: begin
                    if (accept) begin
                        state_d = EXEC;
                    end else if (handshake) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Operand capture on accept; these feed the FPU for the whole EXEC period.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            op_q   <= 4'd0;
            rd_q   <= 5'd0;
            src1_q <= 32'd0;
            src2_q <= 32'd0;
        end else if (accept) begin
            op_q   <= in_op;
            rd_q   <= in_rd;
            src1_q <= in_src1;
            src2_q <= in_src2;
        end
    end

    // Result capture at the end of EXEC; illegal ops yield zero.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            data_q <= 32'd0;
            ovf_q  <= 1'b0;
        end else if (capture) begin
            data_q <= op_is_legal(op_q) ? fpu_result : 32'd0;
            ovf_q  <= cap_ovf;
        end
    end

`ifdef FPU_STICKY_OVF_EN
    logic sticky_q;

    // Sticky overflow: set wins over clear; flush leaves it untouched.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sticky_q <= 1'b0;
        end else if (capture && cap_ovf) begin
            sticky_q <= 1'b1;
        end else if (ovf_clr && !flush) begin
            sticky_q <= 1'b0;
        end
    end

    assign ovf_sticky = sticky_q;
`else
    logic unused_ovf_clr;
    assign unused_ovf_clr = ovf_clr;
    assign ovf_sticky     = 1'b0;
`endif

    assign fpu_op   = op_q;
    assign fpu_src1 = src1_q;
    assign fpu_src2 = src2_q;
    assign out_rd   = rd_q;
    assign out_data = data_q;
    assign out_ovf  = ovf_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_fpu_exec_ctrl.sv
// Scoreboard bench for fpu_exec_ctrl with a table-driven stand-in FPU.
`timescale 1ns/1ps
module tb_fpu_exec_ctrl;
    import fpu_pkg::*;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  in_op = 4'd0;
    logic [4:0]  in_rd = 5'd0;
    logic [31:0] in_src1 = 32'd0;
    logic [31:0] in_src2 = 32'd0;
    logic [31:0] fpu_src1, fpu_src2;
    logic [3:0]  fpu_op;
    logic [31:0] fpu_result;
    logic        fpu_ovf;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [4:0]  out_rd;
    logic [31:0] out_data;
    logic        out_ovf;
    logic        busy;
    logic        ovf_sticky;
    logic        ovf_clr = 1'b0;

    fpu_exec_ctrl dut (
        .clk        (clk),
        .rstn       (rstn),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_rd      (in_rd),
        .in_src1    (in_src1),
        .in_src2    (in_src2),
        .fpu_src1   (fpu_src1),
        .fpu_src2   (fpu_src2),
        .fpu_op     (fpu_op),
        .fpu_result (fpu_result),
        .fpu_ovf    (fpu_ovf),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_rd     (out_rd),
        .out_data   (out_data),
        .out_ovf    (out_ovf),
        .busy       (busy),
        .ovf_sticky (ovf_sticky),
        .ovf_clr    (ovf_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [4:0]  rd;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] fres;
        logic        fovf;
        logic [31:0] exp_data;
        logic        exp_ovf;
        int          lat;
    } vec_t;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        logic        ovf;
        int          lat;
        int          acc;
    } exp_t;

    localparam int NV = 9;
    vec_t vecs [NV];
    exp_t sb [$];
    exp_t mon_e;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    bit   seen = 1'b0;
    logic exp_sticky;

    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in FPU: answers only the operand triples in the table, so wrong
    // operands or opcode routed to the FPU show up as a wrong result.
    always_comb begin
        fpu_result = 32'hDEAD_BEEF;
        fpu_ovf    = 1'b1;
        for (int i = 0; i < NV; i++) begin
            if (fpu_op == vecs[i].op && fpu_src1 == vecs[i].a && fpu_src2 == vecs[i].b) begin
                fpu_result = vecs[i].fres;
                fpu_ovf    = vecs[i].fovf;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic setv(input int i, input logic [3:0] op, input logic [4:0] rd,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] fres, input logic fovf,
                        input logic [31:0] ed, input logic eo, input int lat);
        vecs[i].op = op;   vecs[i].rd = rd;     vecs[i].a = a;         vecs[i].b = b;
        vecs[i].fres = fres; vecs[i].fovf = fovf;
        vecs[i].exp_data = ed; vecs[i].exp_ovf = eo; vecs[i].lat = lat;
    endtask

    // Present a vector until accepted; expected response is queued on accept.
    task automatic issue(input int idx, output int acc);
        exp_t e;
        acc      = -1;
        in_valid = 1'b1;
        in_op    = vecs[idx].op;
        in_rd    = vecs[idx].rd;
        in_src1  = vecs[idx].a;
        in_src2  = vecs[idx].b;
        for (int k = 0; k < 50 && acc < 0; k++) begin
            @(negedge clk);
            if (in_ready) begin
                acc      = cyc + 1;
                e.rd     = vecs[idx].rd;
                e.data   = vecs[idx].exp_data;
                e.ovf    = vecs[idx].exp_ovf;
                e.lat    = vecs[idx].lat;
                e.acc    = acc;
                sb.push_back(e);
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (acc < 0) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain(input int budget);
        int k = 0;
        while (sb.size() != 0 && k < budget) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (sb.size() != 0) begin
            chk("drain_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
            seen = 1'b0;
        end
    endtask

    // Monitor: checks latency on the first valid cycle, then that the result
    // holds until the handshake, then retires the entry.
    always @(negedge clk) begin
        if (rstn) begin
            if (out_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_valid", 32'(out_valid), 32'd0);
                end else begin
                    mon_e = sb[0];
                    if (!seen) begin
                        chk("latency", 32'(cyc - mon_e.acc), 32'(mon_e.lat));
                        seen = 1'b1;
                    end
                    chk("out_rd", 32'(out_rd), 32'(mon_e.rd));
                    chk("out_data", out_data, mon_e.data);
                    chk("out_ovf", 32'(out_ovf), 32'(mon_e.ovf));
                    if (out_ready) begin
                        void'(sb.pop_front());
                        seen = 1'b0;
                    end
                end
            end else if (seen) begin
                chk("valid_held", 32'(out_valid), 32'd1);
            end
        end
    end

    initial begin
        int acc_a, acc_b, k;
        setv(0, FADD,   5'd1, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 1'b0,
             32'h4040_0000, 1'b0, 2);
        setv(1, FDIV,   5'd2, 32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 1'b0,
             32'h4040_0000, 1'b0, 6);
        setv(2, FEQ,    5'd3, 32'h3F80_0000, 32'h3F80_0000, 32'h0000_0001, 1'b1,
             32'h0000_0001, 1'b0, 1);
        setv(3, FMUL,   5'd4, 32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 1'b0,
             32'h40C0_0000, 1'b0, 2);
        setv(4, FMUL,   5'd5, 32'h7F00_0000, 32'h7F00_0000, 32'h7F80_0000, 1'b1,
             32'h7F80_0000, 1'b1, 2);
        setv(5, 4'd12,  5'd6, 32'h1111_1111, 32'h2222_2222, 32'h1234_5678, 1'b1,
             32'h0000_0000, 1'b0, 1);
        setv(6, FSUB,   5'd7, 32'h4040_0000, 32'h3F80_0000, 32'h4000_0000, 1'b0,
             32'h4000_0000, 1'b0, 2);
        setv(7, FSGNJN, 5'd8, 32'h3F80_0000, 32'h3F80_0000, 32'hBF80_0000, 1'b1,
             32'hBF80_0000, 1'b0, 1);
        setv(8, FLT,    5'd9, 32'h3F80_0000, 32'h4000_0000, 32'h0000_0001, 1'b0,
             32'h0000_0001, 1'b0, 1);
`ifdef FPU_STICKY_OVF_EN
        exp_sticky = 1'b1;
`else
        exp_sticky = 1'b0;
`endif

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_rd", 32'(out_rd), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_ovf", 32'(out_ovf), 32'd0);
        chk("rst_fpu_src1", fpu_src1, 32'd0);
        chk("rst_fpu_src2", fpu_src2, 32'd0);
        chk("rst_fpu_op", 32'(fpu_op), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_sticky", 32'(ovf_sticky), 32'd0);
        @(posedge clk);
        #1 rstn = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // FADD 1.0 + 2.0
        issue(0, acc_a);
        drain(20);

        // FDIV with a 3-cycle writeback stall
        out_ready = 1'b0;
        issue(1, acc_a);
        for (k = 0; k < 20 && !out_valid; k++) begin
            chk("in_ready_exec", 32'(in_ready), 32'd0);
            @(negedge clk);
        end
        for (int j = 0; j < 3; j++) begin
            chk("in_ready_stall", 32'(in_ready), 32'd0);
            @(negedge clk);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        drain(20);

        // FEQ then FMUL back to back
        issue(2, acc_a);
        issue(3, acc_b);
        chk("b2b_accept_gap", 32'(acc_b - acc_a), 32'd2);
        drain(20);

        // Illegal opcode and the non-arithmetic/garbage-overflow ops
        issue(5, acc_a);
        issue(6, acc_a);
        issue(7, acc_a);
        issue(8, acc_a);
        drain(30);
        chk("sticky_quiet", 32'(ovf_sticky), 32'd0);

        // Overflowing FMUL and sticky flag
        issue(4, acc_a);
        drain(20);
        chk("sticky_after_ovf", 32'(ovf_sticky), 32'(exp_sticky));
        ovf_clr = 1'b1;
        @(posedge clk);
        #1 ovf_clr = 1'b0;
        chk("sticky_cleared", 32'(ovf_sticky), 32'd0);

        // Flush mid-FDIV while another op is offered
        issue(1, acc_a);
        repeat (3) @(posedge clk);
        #1;
        flush    = 1'b1;
        in_valid = 1'b1;
        in_op    = vecs[0].op;
        in_rd    = vecs[0].rd;
        in_src1  = vecs[0].a;
        in_src2  = vecs[0].b;
        sb.delete();
        seen = 1'b0;
        @(negedge clk);
        chk("flush_in_ready", 32'(in_ready), 32'd0);
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_busy", 32'(busy), 32'd0);
        @(negedge clk);
        chk("flush_in_ready_after", 32'(in_ready), 32'd1);
        repeat (10) @(posedge clk);
        #1;

        // Reset pulse while holding a result in DONE
        out_ready = 1'b0;
        issue(6, acc_a);
        for (k = 0; k < 20 && !out_valid; k++) @(negedge clk);
        chk("done_reached", 32'(out_valid), 32'd1);
        @(posedge clk);
        #1 rstn = 1'b0;
        sb.delete();
        seen = 1'b0;
        #1;
        chk("rst_done_out_valid", 32'(out_valid), 32'd0);
        chk("rst_done_busy", 32'(busy), 32'd0);
        chk("rst_done_out_data", out_data, 32'd0);
        @(posedge clk);
        #1 rstn = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("rst_done_in_ready", 32'(in_ready), 32'd1);
        chk("rst_done_idle", 32'(busy), 32'd0);
        repeat (5) @(posedge clk);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fpu_exec_ctrl.md
FPU_EXEC_CTRL -- requirements
Module: fpu_exec_ctrl

Interface
REQ-001 SHALL have parameter ADD_LAT, default 2, cycles from accept to result for FADD/FSUB.
REQ-002 SHALL have parameter MUL_LAT, default 2, cycles for FMUL.
REQ-003 SHALL have parameter DIV_LAT, default 6, cycles for FDIV; all latencies legal range 1..15.
REQ-004 SHALL have ports, one per line (name, direction, width, meaning):
- clk  in  1  sole clock, rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- flush  in  1  synchronous abort of in-flight op.
- in_valid  in  1  upstream op valid.
- in_ready  out  1  stage can accept.
- in_op  in  4  fpu_op_t opcode.
- in_rd  in  5  destination register.
- in_src1  in  32  operand 1.
- in_src2  in  32  operand 2.
- fpu_src1  out  32  operand 1 to combinational FPU.
- fpu_src2  out  32  operand 2 to combinational FPU.
- fpu_op  out  4  held opcode to FPU selector.
- fpu_result  in  32  FPU result.
- fpu_ovf  in  1  FPU overflow.
- out_valid  out  1  writeback valid.
- out_ready  in  1  writeback accepts.
- out_rd  out  5  destination register.
- out_data  out  32  captured result.
- out_ovf  out  1  captured overflow.
- busy  out  1  state != IDLE.
- ovf_sticky  out  1  accumulated overflow status.
- ovf_clr  in  1  clears ovf_sticky.

Function
REQ-005 SHALL implement FSM states IDLE, EXEC, DONE.
REQ-006 in_ready SHALL be 1 in IDLE, or in DONE when out_ready=1; 0 otherwise (EXEC) and 0 while flush=1.
REQ-007 On accept edge (in_valid&in_ready): capture op, rd, src1, src2; load counter with L-1; go EXEC.
REQ-008 L SHALL be ADD_LAT for FADD/FSUB, MUL_LAT for FMUL, DIV_LAT for FDIV, 1 for FSGNJ/FSGNJN/FEQ/FLT/FLE and for illegal opcodes.
REQ-009 fpu_src1/fpu_src2/fpu_op SHALL be driven from captured registers, stable for the whole EXEC period.
REQ-010 In EXEC with counter!=0: decrement; with counter==0: capture fpu_result->out_data, fpu_ovf->out_ovf, go DONE.
REQ-011 out_valid SHALL rise exactly L cycles after the accept edge and stay high, with out_rd/out_data/out_ovf stable, until the out_valid&out_ready edge.
REQ-012 Illegal opcode (9..15) SHALL produce out_data=0, out_ovf=0.
REQ-013 On handshake edge in DONE: if a new op is accepted on the same edge go EXEC (back-to-back, no bubble), else go IDLE.
REQ-014 out_ovf SHALL be forced 0 for non-arithmetic ops (FSGNJ..FLE).
REQ-015 flush=1 SHALL win over all other events: next state IDLE, out_valid=0, no accept; captured data discarded; ovf_sticky unchanged.

Reset
REQ-016 On rstn=0: state IDLE, counter 0, out_valid 0, out_rd 0, out_data 0, out_ovf 0, fpu_src1/2 0, fpu_op 0, ovf_sticky 0, busy 0; in_ready 1 after reset release.
REQ-017 Reset mid-EXEC or mid-DONE SHALL abandon the op with no output handshake.

Configuration
REQ-018 Macro FPU_STICKY_OVF_EN defined: ovf_sticky sets on the REQ-010 capture edge when out_ovf captured 1; ovf_clr clears it; set wins on simultaneous set and clear.
REQ-019 Macro undefined: ovf_sticky tied 0, ovf_clr ignored, no sticky flop.

Structure
REQ-020 Shared package fpu_pkg SHALL hold fpu_op_t (FADD=0, FSUB=1, FMUL=2, FDIV=3, FSGNJ=4, FSGNJN=5, FEQ=6, FLT=7, FLE=8), the FSM state enum, and a latency-lookup function.
REQ-021 One sub-module fpu_lat_counter (load/decrement/zero flag, 4-bit) SHALL be used; no other hierarchy.

Verification
REQ-022 FADD 0x3F800000+0x40000000, out_ready=1 -> out_valid 2 cycles after accept, out_data=0x40400000, out_ovf=0.
REQ-023 FDIV with out_ready=0 for 3 extra cycles -> out_valid at +6, out_data held stable until ready, in_ready=0 throughout EXEC.
REQ-024 FEQ then FMUL back-to-back with out_ready=1 -> FEQ result at +1, FMUL accepted same edge, FMUL result at +2 more, no bubble.
REQ-025 FMUL 0x7F000000*0x7F000000 -> out_ovf=1; with FPU_STICKY_OVF_EN ovf_sticky=1 until ovf_clr; without it ovf_sticky=0.
REQ-026 flush during FDIV EXEC, then rstn pulse during DONE -> no out_valid either time, state IDLE, in_ready=1 next cycle.
REQ-027 in_op=12 -> out_data=0, out_ovf=0 after 1 cycle.
